// File: rtl/pcs_code_sync.sv
// 1000BASE-X PCS receive code-group synchronizer: comma acquisition, disparity check, bad/good hysteresis.
// Optional saturating bad-code-group statistics counter enabled by `define PCS_SYNC_STATS_EN.
//
// state         | meaning
// LOSS_OF_SYNC  | hunting for a comma; all counters held at zero
// ACQUIRE       | counting even-slot commas; any bad code group drops back
// SYNC_ACQUIRED | aligned; bad/good counters provide loss hysteresis
module pcs_code_sync #(
    parameter int COMMAS_TO_SYNC      = 3,
    parameter int MAX_BAD_CGS         = 4,
    parameter int GOOD_CGS_TO_RECOVER = 4,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 power,
    input  logic [9:0]           rx_code_group,
    output logic [9:0]           sync_code_group,
    output logic                 RX_EVEN,
    output logic                 sync_status
`ifdef PCS_SYNC_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] cg_error_count
`endif
);

    if (COMMAS_TO_SYNC < 1 || COMMAS_TO_SYNC > 15 || MAX_BAD_CGS < 1 || MAX_BAD_CGS > 15 ||
        GOOD_CGS_TO_RECOVER < 1 || GOOD_CGS_TO_RECOVER > 15 || CNT_WIDTH < 1) begin : g_param_check
        $error("pcs_code_sync: parameter out of range");
    end

    typedef enum logic [1:0] {
        LOSS_OF_SYNC,
        ACQUIRE,
        SYNC_ACQUIRED
    } state_t;

    state_t     state;
    logic       rd_pos;
    logic [3:0] comma_cnt;
    logic [3:0] bad_cnt;
    logic [3:0] good_cnt;

    logic [3:0] ones;
    logic       comma;
    logic       cg_valid;
    logic       next_even;
    logic       bad;
    logic       bad_limit;

    assign ones      = 4'($countones(rx_code_group));
    assign comma     = (rx_code_group[9:3] == 7'b0011111) || (rx_code_group[9:3] == 7'b1100000);
    assign cg_valid  = (ones == 4'd5) || (ones == 4'd6 && !rd_pos) || (ones == 4'd4 && rd_pos);
    assign next_even = (state == LOSS_OF_SYNC && comma) ? 1'b1 : ~RX_EVEN;
    assign bad       = !cg_valid || (comma && !next_even);
    assign bad_limit = (bad_cnt + 4'd1) == 4'(MAX_BAD_CGS);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= LOSS_OF_SYNC;
            rd_pos          <= 1'b0;
            comma_cnt       <= 4'd0;
            bad_cnt         <= 4'd0;
            good_cnt        <= 4'd0;
            sync_code_group <= 10'd0;
            RX_EVEN         <= 1'b0;
            sync_status     <= 1'b0;
        end else begin
            sync_code_group <= rx_code_group;
            if (!power) begin
                // Signal loss ignores the data entirely; disparity history is kept.
                RX_EVEN     <= ~RX_EVEN;
                state       <= LOSS_OF_SYNC;
                comma_cnt   <= 4'd0;
                bad_cnt     <= 4'd0;
                good_cnt    <= 4'd0;
                sync_status <= 1'b0;
            end else begin
                RX_EVEN <= next_even;
                if (cg_valid && ones == 4'd6) rd_pos <= 1'b1;
                else if (cg_valid && ones == 4'd4) rd_pos <= 1'b0;

                case (state)
                    LOSS_OF_SYNC: begin
                        sync_status <= 1'b0;
                        comma_cnt   <= 4'd0;
                        bad_cnt     <= 4'd0;
                        good_cnt    <= 4'd0;
                        if (comma) begin
                            comma_cnt <= 4'd1;
                            if (COMMAS_TO_SYNC == 1) begin
                                state       <= SYNC_ACQUIRED;
                                sync_status <= 1'b1;
                            end else begin
                                state <= ACQUIRE;
                            end
                        end
                    end
                    ACQUIRE: begin
                        if (bad) begin
                            state     <= LOSS_OF_SYNC;
                            comma_cnt <= 4'd0;
                        end else if (comma) begin
                            comma_cnt <= comma_cnt + 4'd1;
                            if ((comma_cnt + 4'd1) == 4'(COMMAS_TO_SYNC)) begin
                                state       <= SYNC_ACQUIRED;
                                sync_status <= 1'b1;
                                bad_cnt     <= 4'd0;
                                good_cnt    <= 4'd0;
                            end
                        end
                    end
                    SYNC_ACQUIRED: begin
                        if (bad) begin
                            good_cnt <= 4'd0;
                            if (bad_limit) begin
                                state       <= LOSS_OF_SYNC;
                                sync_status <= 1'b0;
                                bad_cnt     <= 4'd0;
                                comma_cnt   <= 4'd0;
                            end else begin
                                bad_cnt <= bad_cnt + 4'd1;
                            end
                        end else if (bad_cnt != 4'd0) begin
                            if ((good_cnt + 4'd1) == 4'(GOOD_CGS_TO_RECOVER)) begin
                                bad_cnt  <= bad_cnt - 4'd1;
                                good_cnt <= 4'd0;
                            end else begin
                                good_cnt <= good_cnt + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state       <= LOSS_OF_SYNC;
                        sync_status <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PCS_SYNC_STATS_EN
    // The bad code group that drops sync also counts the loss itself, hence +2.
    logic [CNT_WIDTH+1:0] err_sum;
    assign err_sum = {2'b00, cg_error_count} + (CNT_WIDTH + 2)'(bad_limit ? 2 : 1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cg_error_count <= '0;
        end else if (power && state == SYNC_ACQUIRED && bad) begin
            if (err_sum > {2'b00, {CNT_WIDTH{1'b1}}}) cg_error_count <= '1;
            else cg_error_count <= err_sum[CNT_WIDTH-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_pcs_code_sync.sv
// Scoreboard bench for pcs_code_sync: directed test-plan sequences then randomized traffic,
// expected outputs come from a rule-level reference model and are checked by a separate monitor.
module tb_pcs_code_sync;

    localparam int C_SYNC = 3;
    localparam int M_BAD  = 4;
    localparam int G_REC  = 4;
`ifdef PCS_SYNC_STATS_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif
    localparam int ERR_MAX = (CW >= 31) ? 32'h7fffffff : ((1 << CW) - 1);

    localparam logic [9:0] K28P = 10'b0011111010;
    localparam logic [9:0] K28N = 10'b1100000101;
    localparam logic [9:0] D162 = 10'b1001000101;
    localparam logic [9:0] D215 = 10'b1010101010;
    localparam logic [9:0] ZERO = 10'b0000000000;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          power = 1'b1;
    logic [9:0]    rx_code_group = 10'd0;
    logic [9:0]    sync_code_group;
    logic          RX_EVEN;
    logic          sync_status;
`ifdef PCS_SYNC_STATS_EN
    logic [CW-1:0] cg_error_count;
`endif

    pcs_code_sync #(
        .COMMAS_TO_SYNC(C_SYNC),
        .MAX_BAD_CGS(M_BAD),
        .GOOD_CGS_TO_RECOVER(G_REC),
        .CNT_WIDTH(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .power(power),
        .rx_code_group(rx_code_group),
        .sync_code_group(sync_code_group),
        .RX_EVEN(RX_EVEN),
        .sync_status(sync_status)
`ifdef PCS_SYNC_STATS_EN
        ,
        .cg_error_count(cg_error_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [9:0] code;
        logic       even;
        logic       sync;
        int         err;
        int         idx;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   issued = 0;

    // Reference model: "hunting / counting / locked" phases with plain integer counters.
    int   m_phase;
    bit   m_rd_pos;
    bit   m_even;
    int   m_commas, m_bads, m_goods, m_err;

    task automatic check(input string name, input int idx, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_rd_pos = 0; m_even = 0;
        m_commas = 0; m_bads = 0; m_goods = 0; m_err = 0;
    endtask

    task automatic model_step(input logic [9:0] cg, input bit pwr, output exp_t e);
        int ones;
        bit comma, ok, nev, bad;
        ones  = $countones(cg);
        comma = (cg[9:3] == 7'h1F) || (cg[9:3] == 7'h60);
        if (!pwr) begin
            m_even = !m_even;
            m_phase = 0; m_commas = 0; m_bads = 0; m_goods = 0;
        end else begin
            ok  = (ones == 5) || (ones == 6 && !m_rd_pos) || (ones == 4 && m_rd_pos);
            nev = (m_phase == 0 && comma) ? 1'b1 : !m_even;
            bad = !ok || (comma && !nev);
            if (ok && ones == 6) m_rd_pos = 1;
            if (ok && ones == 4) m_rd_pos = 0;
            m_even = nev;
            if (m_phase == 0) begin
                if (comma) begin
                    m_commas = 1; m_bads = 0; m_goods = 0;
                    m_phase = (C_SYNC == 1) ? 2 : 1;
                end
            end else if (m_phase == 1) begin
                if (bad) begin
                    m_phase = 0; m_commas = 0;
                end else if (comma) begin
                    m_commas++;
                    if (m_commas == C_SYNC) begin
                        m_phase = 2; m_bads = 0; m_goods = 0;
                    end
                end
            end else begin
                if (bad) begin
                    m_bads++; m_goods = 0; m_err++;
                    if (m_bads == M_BAD) begin
                        m_phase = 0; m_bads = 0; m_commas = 0; m_err++;
                    end
                    if (m_err > ERR_MAX) m_err = ERR_MAX;
                end else if (m_bads > 0) begin
                    m_goods++;
                    if (m_goods == G_REC) begin
                        m_bads--; m_goods = 0;
                    end
                end
            end
        end
        e.code = cg;
        e.even = m_even;
        e.sync = (m_phase == 2);
        e.err  = m_err;
        e.idx  = issued;
    endtask

    task automatic send(input logic [9:0] cg, input bit pwr);
        exp_t e;
        @(negedge clock);
        rx_code_group = cg;
        power = pwr;
        model_step(cg, pwr, e);
        sb_q.push_back(e);
        issued++;
    endtask

    task automatic idle(input int pairs);
        for (int i = 0; i < pairs; i++) begin
            send(K28P, 1'b1);
            send(D162, 1'b1);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " code"}, issued, int'(sync_code_group), 0);
        check({tag, " even"}, issued, int'(RX_EVEN), 0);
        check({tag, " sync"}, issued, int'(sync_status), 0);
`ifdef PCS_SYNC_STATS_EN
        check({tag, " errcnt"}, issued, int'(cg_error_count), 0);
`endif
    endtask

    // Monitor: every clock presents one aligned output word while out of reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (reset && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sync_code_group", e.idx, int'(sync_code_group), int'(e.code));
                check("RX_EVEN", e.idx, int'(RX_EVEN), int'(e.even));
                check("sync_status", e.idx, int'(sync_status), int'(e.sync));
`ifdef PCS_SYNC_STATS_EN
                check("cg_error_count", e.idx, int'(cg_error_count), e.err);
`endif
            end
        end
    end

    initial begin
        int r;
        logic [9:0] cg;
        bit alt;
        model_reset();

        // Reset held 3 cycles.
        #1 check_reset_values("reset");
        repeat (3) @(negedge clock);
        check_reset_values("reset held");
        reset = 1'b1;

        // Acquire on the 3rd K28.5, then hold.
        idle(4);
        // Loss by four bad code groups.
        repeat (4) send(ZERO, 1'b1);
        // Odd-slot comma during acquire, then fresh re-acquire.
        idle(2);
        send(D215, 1'b1);
        send(K28P, 1'b1);
        send(D162, 1'b1);
        idle(4);
        // Hysteresis: 3 bad, 12 good, 3 bad stays synced; one more drops it.
        repeat (3) send(ZERO, 1'b1);
        repeat (12) send(D215, 1'b1);
        repeat (3) send(ZERO, 1'b1);
        send(ZERO, 1'b1);
        // Disparity: back-to-back K28.5 RD- while synced.
        idle(3);
        send(K28P, 1'b1);
        send(K28P, 1'b1);
        send(K28N, 1'b1);
        idle(3);
        // Power low for one cycle while synced.
        send(D162, 1'b0);
        idle(4);
        // Five bad code groups while synced (error counter saturation).
        repeat (5) send(ZERO, 1'b1);
        idle(4);

        // Reset mid-operation returns outputs to reset values immediately.
        @(negedge clock);
        reset = 1'b0;
        #1 check_reset_values("mid reset");
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        idle(4);

        // Randomized traffic.
        alt = 0;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 50) begin
                cg = alt ? D162 : K28P;
                alt = !alt;
            end else if (r < 65) cg = D215;
            else if (r < 73) cg = K28N;
            else if (r < 80) cg = ZERO;
            else if (r < 85) cg = K28P;
            else cg = 10'($urandom);
            send(cg, ($urandom_range(0, 99) >= 2));
        end
        send(D215, 1'b1);

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clock);
        check("scoreboard drained", issued, sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
